// File: rtl/rename_regfile.sv
// Architectural register file with per-register ROB rename tags.
// Commits from the ROB write data; the dispatcher tags registers busy and reads two sources.
module rename_regfile #(
    parameter int REG_NUM    = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32,
    parameter int ROB_ID_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  clr_i,
    input  logic                  wEn_i,
    input  logic [ROB_ID_W-1:0]   wId_i,
    input  logic [REG_ADDR_W-1:0] wAddr_i,
    input  logic [DATA_W-1:0]     wData_i,
    input  logic                  tagEn_i,
    input  logic [REG_ADDR_W-1:0] tagAddr_i,
    input  logic [ROB_ID_W-1:0]   tagId_i,
    input  logic [REG_ADDR_W-1:0] r1Addr_i,
    output logic                  r1Busy_o,
    output logic [ROB_ID_W-1:0]   r1Id_o,
    output logic [DATA_W-1:0]     r1Data_o,
    input  logic [REG_ADDR_W-1:0] r2Addr_i,
    output logic                  r2Busy_o,
    output logic [ROB_ID_W-1:0]   r2Id_o,
    output logic [DATA_W-1:0]     r2Data_o
);

    logic [DATA_W-1:0]   data_q [REG_NUM];
    logic [ROB_ID_W-1:0] tag_q  [REG_NUM];
    logic [REG_NUM-1:0]  busy_q;

    logic commit_ok;
    logic rename_ok;

    assign commit_ok = wEn_i && (wAddr_i != '0);
    assign rename_ok = tagEn_i && (tagAddr_i != '0) && (tagId_i != '0) && !clr_i;

    // Later assignments win: rename overrides a commit's tag clear, flush overrides both.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '{default: '0};
            tag_q  <= '{default: '0};
            busy_q <= '0;
        end else if (rdy) begin
            if (commit_ok) begin
                data_q[wAddr_i] <= wData_i;
                if (busy_q[wAddr_i] && (tag_q[wAddr_i] == wId_i)) begin
                    busy_q[wAddr_i] <= 1'b0;
                    tag_q[wAddr_i]  <= '0;
                end
            end
            if (rename_ok) begin
                busy_q[tagAddr_i] <= 1'b1;
                tag_q[tagAddr_i]  <= tagId_i;
            end
            if (clr_i) begin
                busy_q <= '0;
                tag_q  <= '{default: '0};
            end
        end
    end

    always_comb begin
        r1Busy_o = 1'b0;
        r1Id_o   = '0;
        r1Data_o = '0;
        if (rst || (r1Addr_i == '0)) begin
            r1Busy_o = 1'b0;
        end else if (busy_q[r1Addr_i] && wEn_i && (wAddr_i == r1Addr_i)
                     && (wId_i == tag_q[r1Addr_i])) begin
            r1Data_o = wData_i;
        end else if (busy_q[r1Addr_i]) begin
            r1Busy_o = 1'b1;
            r1Id_o   = tag_q[r1Addr_i];
        end else begin
            r1Data_o = data_q[r1Addr_i];
        end
    end

    always_comb begin
        r2Busy_o = 1'b0;
        r2Id_o   = '0;
        r2Data_o = '0;
        if (rst || (r2Addr_i == '0)) begin
            r2Busy_o = 1'b0;
        end else if (busy_q[r2Addr_i] && wEn_i && (wAddr_i == r2Addr_i)
                     && (wId_i == tag_q[r2Addr_i])) begin
            r2Data_o = wData_i;
        end else if (busy_q[r2Addr_i]) begin
            r2Busy_o = 1'b1;
            r2Id_o   = tag_q[r2Addr_i];
        end else begin
            r2Data_o = data_q[r2Addr_i];
        end
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed self-checking bench for rename_regfile.
module tb_rename_regfile;

    logic        clk = 1'b0;
    logic        rst, rdy, clr_i, wEn_i, tagEn_i;
    logic [4:0]  wId_i, wAddr_i, tagAddr_i, tagId_i, r1Addr_i, r2Addr_i;
    logic [31:0] wData_i;
    logic        r1Busy_o, r2Busy_o;
    logic [4:0]  r1Id_o, r2Id_o;
    logic [31:0] r1Data_o, r2Data_o;

    int checks = 0;
    int errors = 0;

    rename_regfile #(.REG_NUM(32), .REG_ADDR_W(5), .DATA_W(32), .ROB_ID_W(5)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr_i(clr_i),
        .wEn_i(wEn_i), .wId_i(wId_i), .wAddr_i(wAddr_i), .wData_i(wData_i),
        .tagEn_i(tagEn_i), .tagAddr_i(tagAddr_i), .tagId_i(tagId_i),
        .r1Addr_i(r1Addr_i), .r1Busy_o(r1Busy_o), .r1Id_o(r1Id_o), .r1Data_o(r1Data_o),
        .r2Addr_i(r2Addr_i), .r2Busy_o(r2Busy_o), .r2Id_o(r2Id_o), .r2Data_o(r2Data_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wEn_i = 1'b0; tagEn_i = 1'b0; clr_i = 1'b0;
        wId_i = '0; wAddr_i = '0; wData_i = '0; tagAddr_i = '0; tagId_i = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; idle(); r1Addr_i = 5'd5; r2Addr_i = 5'd0;
        step(); step();
        rst = 1'b0;
        #1;
        checks++;
        if ({r1Busy_o, r1Id_o, r1Data_o} !== 38'd0) begin
            errors++; $display("FAIL reset_x5 got busy=%0b id=%0d data=%h want 0/0/0", r1Busy_o, r1Id_o, r1Data_o);
        end
        checks++;
        if ({r2Busy_o, r2Id_o, r2Data_o} !== 38'd0) begin
            errors++; $display("FAIL reset_x0 got busy=%0b id=%0d data=%h want 0/0/0", r2Busy_o, r2Id_o, r2Data_o);
        end
    endtask

    task automatic test_commit();
        wEn_i = 1'b1; wAddr_i = 5'd3; wData_i = 32'hDEADBEEF; wId_i = 5'd4; r1Addr_i = 5'd3;
        #1;
        checks++;
        if (r1Data_o !== 32'h0) begin
            errors++; $display("FAIL commit_pre got data=%h want 00000000", r1Data_o);
        end
        step(); idle();
        checks++;
        if (r1Busy_o !== 1'b0 || r1Data_o !== 32'hDEADBEEF) begin
            errors++; $display("FAIL commit_x3 got busy=%0b data=%h want 0/deadbeef", r1Busy_o, r1Data_o);
        end
        wEn_i = 1'b1; wAddr_i = 5'd0; wData_i = 32'hFFFF_FFFF; r2Addr_i = 5'd0;
        step(); idle();
        checks++;
        if ({r2Busy_o, r2Id_o, r2Data_o} !== 38'd0) begin
            errors++; $display("FAIL commit_x0 got busy=%0b id=%0d data=%h want 0/0/0", r2Busy_o, r2Id_o, r2Data_o);
        end
    endtask

    task automatic test_bypass();
        tagEn_i = 1'b1; tagAddr_i = 5'd7; tagId_i = 5'd9; r1Addr_i = 5'd7;
        #1;
        checks++;
        if (r1Busy_o !== 1'b0) begin
            errors++; $display("FAIL rename_invisible got busy=%0b want 0", r1Busy_o);
        end
        step(); idle();
        checks++;
        if (r1Busy_o !== 1'b1 || r1Id_o !== 5'd9 || r1Data_o !== 32'h0) begin
            errors++; $display("FAIL rename_x7 got busy=%0b id=%0d data=%h want 1/9/0", r1Busy_o, r1Id_o, r1Data_o);
        end
        wEn_i = 1'b1; wAddr_i = 5'd7; wId_i = 5'd9; wData_i = 32'h55;
        #1;
        checks++;
        if (r1Busy_o !== 1'b0 || r1Id_o !== 5'd0 || r1Data_o !== 32'h55) begin
            errors++; $display("FAIL bypass_x7 got busy=%0b id=%0d data=%h want 0/0/55", r1Busy_o, r1Id_o, r1Data_o);
        end
        step(); idle();
        checks++;
        if (r1Busy_o !== 1'b0 || r1Data_o !== 32'h55) begin
            errors++; $display("FAIL commit_x7 got busy=%0b data=%h want 0/55", r1Busy_o, r1Data_o);
        end
    endtask

    task automatic test_younger();
        tagEn_i = 1'b1; tagAddr_i = 5'd7; tagId_i = 5'd9; step();
        tagId_i = 5'd12; step(); idle();
        wEn_i = 1'b1; wAddr_i = 5'd7; wId_i = 5'd9; wData_i = 32'h11; r1Addr_i = 5'd7;
        #1;
        checks++;
        if (r1Busy_o !== 1'b1 || r1Id_o !== 5'd12 || r1Data_o !== 32'h0) begin
            errors++; $display("FAIL younger_nobypass got busy=%0b id=%0d data=%h want 1/12/0", r1Busy_o, r1Id_o, r1Data_o);
        end
        step(); idle();
        checks++;
        if (r1Busy_o !== 1'b1 || r1Id_o !== 5'd12) begin
            errors++; $display("FAIL younger_keep got busy=%0b id=%0d want 1/12", r1Busy_o, r1Id_o);
        end
        clr_i = 1'b1; step(); idle();
        checks++;
        if (r1Busy_o !== 1'b0 || r1Data_o !== 32'h11) begin
            errors++; $display("FAIL younger_data got busy=%0b data=%h want 0/11", r1Busy_o, r1Data_o);
        end
    endtask

    task automatic test_same_cycle();
        tagEn_i = 1'b1; tagAddr_i = 5'd2; tagId_i = 5'd6; step();
        wEn_i = 1'b1; wAddr_i = 5'd2; wId_i = 5'd6; wData_i = 32'h22;
        tagId_i = 5'd8; r2Addr_i = 5'd2;
        step(); idle();
        checks++;
        if (r2Busy_o !== 1'b1 || r2Id_o !== 5'd8) begin
            errors++; $display("FAIL same_cycle got busy=%0b id=%0d want 1/8", r2Busy_o, r2Id_o);
        end
        clr_i = 1'b1; step(); idle();
        checks++;
        if (r2Busy_o !== 1'b0 || r2Data_o !== 32'h22) begin
            errors++; $display("FAIL same_cycle_data got busy=%0b data=%h want 0/22", r2Busy_o, r2Data_o);
        end
        tagEn_i = 1'b1; tagAddr_i = 5'd10; tagId_i = 5'd0; r2Addr_i = 5'd10;
        step(); idle();
        checks++;
        if (r2Busy_o !== 1'b0 || r2Id_o !== 5'd0) begin
            errors++; $display("FAIL tag_id_zero got busy=%0b id=%0d want 0/0", r2Busy_o, r2Id_o);
        end
    endtask

    task automatic test_flush();
        tagEn_i = 1'b1; tagAddr_i = 5'd1; tagId_i = 5'd1; step();
        tagAddr_i = 5'd2; tagId_i = 5'd2; step();
        tagAddr_i = 5'd3; tagId_i = 5'd3; step(); idle();
        r1Addr_i = 5'd3; r2Addr_i = 5'd1;
        #1;
        checks++;
        if (r1Busy_o !== 1'b1 || r1Id_o !== 5'd3 || r2Busy_o !== 1'b1 || r2Id_o !== 5'd1) begin
            errors++; $display("FAIL flush_pre got r1=%0b/%0d r2=%0b/%0d want 1/3 1/1", r1Busy_o, r1Id_o, r2Busy_o, r2Id_o);
        end
        clr_i = 1'b1; wEn_i = 1'b1; wAddr_i = 5'd4; wId_i = 5'd5; wData_i = 32'h44;
        tagEn_i = 1'b1; tagAddr_i = 5'd5; tagId_i = 5'd7;
        step(); idle();
        checks++;
        if (r1Busy_o !== 1'b0 || r1Data_o !== 32'hDEADBEEF || r2Busy_o !== 1'b0) begin
            errors++; $display("FAIL flush_x3_x1 got r1=%0b/%h r2=%0b want 0/deadbeef 0", r1Busy_o, r1Data_o, r2Busy_o);
        end
        r1Addr_i = 5'd2; r2Addr_i = 5'd4;
        #1;
        checks++;
        if (r1Busy_o !== 1'b0 || r2Busy_o !== 1'b0 || r2Data_o !== 32'h44) begin
            errors++; $display("FAIL flush_x2_x4 got r1=%0b r2=%0b/%h want 0 0/44", r1Busy_o, r2Busy_o, r2Data_o);
        end
        r1Addr_i = 5'd5;
        #1;
        checks++;
        if (r1Busy_o !== 1'b0 || r1Id_o !== 5'd0) begin
            errors++; $display("FAIL flush_rename_drop got busy=%0b id=%0d want 0/0", r1Busy_o, r1Id_o);
        end
    endtask

    task automatic test_rdy();
        tagEn_i = 1'b1; tagAddr_i = 5'd6; tagId_i = 5'd10; step(); idle();
        rdy = 1'b0;
        wEn_i = 1'b1; wAddr_i = 5'd6; wId_i = 5'd10; wData_i = 32'h66;
        tagEn_i = 1'b1; tagAddr_i = 5'd9; tagId_i = 5'd3;
        r1Addr_i = 5'd6; r2Addr_i = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (r1Busy_o !== 1'b0 || r1Data_o !== 32'h66 || r2Busy_o !== 1'b0 || r2Data_o !== 32'h0) begin
                errors++; $display("FAIL rdy_low_read[%0d] got r1=%0b/%h r2=%0b/%h want 0/66 0/0", i, r1Busy_o, r1Data_o, r2Busy_o, r2Data_o);
            end
            step();
        end
        idle();
        #1;
        checks++;
        if (r1Busy_o !== 1'b1 || r1Id_o !== 5'd10 || r2Busy_o !== 1'b0 || r2Id_o !== 5'd0) begin
            errors++; $display("FAIL rdy_low_frozen got r1=%0b/%0d r2=%0b/%0d want 1/10 0/0", r1Busy_o, r1Id_o, r2Busy_o, r2Id_o);
        end
        rdy = 1'b1;
        wEn_i = 1'b1; wAddr_i = 5'd6; wId_i = 5'd10; wData_i = 32'h66;
        step(); idle();
        checks++;
        if (r1Busy_o !== 1'b0 || r1Data_o !== 32'h66) begin
            errors++; $display("FAIL rdy_resume got busy=%0b data=%h want 0/66", r1Busy_o, r1Data_o);
        end
    endtask

    task automatic test_reset_force();
        r1Addr_i = 5'd3; rst = 1'b1;
        #1;
        checks++;
        if (r1Data_o !== 32'h0) begin
            errors++; $display("FAIL reset_force got data=%h want 00000000", r1Data_o);
        end
        step(); rst = 1'b0;
        #1;
        checks++;
        if (r1Data_o !== 32'h0) begin
            errors++; $display("FAIL reset_clears got data=%h want 00000000", r1Data_o);
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_bypass();
        test_younger();
        test_same_cycle();
        test_flush();
        test_rdy();
        test_reset_force();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Architectural register file with per-register ROB rename tags. Sits directly downstream of the reorder buffer, which writes committed results into it.
- The dispatcher sets a register's busy tag when it issues an instruction that writes that register.
- The dispatcher reads two source operands per cycle and gets either a ready value or the ROB id that will produce it.
- A branch flush clears all rename state and keeps committed data.

Parameters:
- REG_NUM, 32, number of architectural registers (x0 hardwired zero)
- REG_ADDR_W, 5, register address width
- DATA_W, 32, data width
- ROB_ID_W, 5, ROB id width; id 0 means "no entry"

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; when low all state is frozen
- clr_i  in  1  branch-mispredict flush
- wEn_i  in  1  commit write enable from the ROB
- wId_i  in  ROB_ID_W  ROB id of the committing entry
- wAddr_i  in  REG_ADDR_W  destination register of the commit
- wData_i  in  DATA_W  committed value
- tagEn_i  in  1  rename request from the dispatcher
- tagAddr_i  in  REG_ADDR_W  register being renamed
- tagId_i  in  ROB_ID_W  ROB id allocated to the new producer
- r1Addr_i  in  REG_ADDR_W  source 1 address
- r1Busy_o  out  1  source 1 value pending in the ROB
- r1Id_o  out  ROB_ID_W  producing ROB id (0 when not busy)
- r1Data_o  out  DATA_W  source 1 value (0 when busy)
- r2Addr_i, r2Busy_o, r2Id_o, r2Data_o: same as port 1

Behaviour:
- State per register: data[i], busy[i], tag[i]. Register 0 is never written or tagged.
- Reset (rst high at posedge): all data, busy and tag cleared to 0.
- While rst is high, the read outputs are forced to 0.
- rdy low: no state updates; the read ports still respond combinationally.
- Commit (rdy and wEn_i and wAddr_i != 0):
  - data[wAddr_i] <= wData_i unconditionally.
  - busy[wAddr_i] <= 0 and tag[wAddr_i] <= 0 only if busy is set and tag == wId_i. Otherwise a younger producer owns the register and its tag stays.
- Rename (rdy and tagEn_i and tagAddr_i != 0 and tagId_i != 0 and not clr_i):
  - busy[tagAddr_i] <= 1 and tag[tagAddr_i] <= tagId_i.
  - tagId_i == 0 is treated as no request.
- Same cycle, same register, commit and rename: the data write still happens; rename wins busy/tag.
- Flush (rdy and clr_i):
  - All busy and tag cleared; any rename that cycle is dropped.
  - A commit presented in the same cycle still writes its data. The ROB asserts its final commit together with clr.
- Reads are purely combinational and show the state before the clock edge.
- Read priority, per port:
  1. addr == 0: busy=0, id=0, data=0.
  2. Commit bypass: busy[addr] and wEn_i and wAddr_i == addr and wId_i == tag[addr] gives busy=0, id=0, data=wData_i.
  3. Else busy[addr]: busy=1, id=tag[addr], data=0.
  4. Else: busy=0, id=0, data=data[addr].
- A rename in the current cycle is not visible on the read ports. This lets an instruction whose rd equals rs read its operand correctly.
- The bypass ignores rdy and clr_i. The consumer discards reads in flush cycles.
- Both read ports are independent and may address the same register.
- No latency on reads; writes are visible from the next cycle.

Test Plan:
- Reset then read x5 and x0 -> both return busy=0, id=0, data=0.
- Commit wAddr=3, data=0xDEADBEEF, id=4 with x3 not busy; read x3 next cycle -> busy=0, data=0xDEADBEEF. Commit to x0 -> x0 reads 0.
- Rename x7 to id 9, then commit x7 with id 9 and data 0x55:
  - Same cycle as the commit: r1 bypass gives busy=0, data=0x55.
  - Next cycle: x7 not busy, data 0x55.
- Rename x7 to id 9, then rename x7 to id 12, then commit x7 with id 9 and data 0x11:
  - x7 stays busy with id 12, data 0x11 stored.
  - Read bypass is not taken: busy=1, id=12.
- Same cycle: commit x2 id 6 data 0x22 (x2 tagged 6) and rename x2 to id 8 -> next cycle x2 busy=1, id=8.
- Tag x1, x2 and x3 busy, then pulse clr_i together with commit x4 data 0x44 -> all registers not busy, x4=0x44, and a rename issued in the clr cycle is ignored.
- rdy low for 3 cycles with commit and rename asserted -> no state change; reads still reflect the prior state and the bypass.
